// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   arb_state_e            : arbiter FSM states (IDLE, BUSY_IF, BUSY_D)
//   req_id_e               : requester identity (REQ_IF fetch, REQ_D data)
//   TIMEOUT_CYCLES_DEFAULT : default wait budget for mem_ready_i
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
// Wait-cycle counter for an outstanding memory transaction.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart counting from zero (asserted on grant)
//   enable   : one cycle spent waiting without mem_ready_i
//   expired  : this waiting cycle is the LIMIT-th one; abort now
module mem_arb_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expire on the waiting cycle whose increment would reach LIMIT, so a
  // transaction that never sees ready spends exactly LIMIT cycles busy.
  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a fetch port and a load/store port onto one memory port.
// Build option: define ARB_FAIRNESS_EN to alternate grants on simultaneous
// requests; otherwise data always wins (fixed priority).
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   if_req_i, if_addr_i               : fetch request and word address
//   if_gnt_o, if_rvalid_o, if_rdata_o : fetch grant, completion pulse, data
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_byte_en_i            : load/store request fields
//   d_gnt_o, d_rvalid_o, d_rdata_o    : data grant, completion pulse, data
//   mem_*                             : shared memory port
//   stall_f_o                         : fetch requested but not granted
//   err_o                             : one-cycle pulse on transaction timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_byte_en_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_byte_en_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_f_o,
  output logic        err_o
);

  arb_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic        mem_req_q;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic        err_q;

  req_id_e     winner;
  logic        idle;
  logic        busy;
  logic        grant_any;
  logic        d_zero_write;
  logic        timer_en;
  logic        timer_expired;

  // Grants are combinational, so they are also masked by rst to keep every
  // output low while reset is held.
  assign idle = (state == IDLE) && !rst;
  assign busy = (state == BUSY_IF) || (state == BUSY_D);

`ifdef ARB_FAIRNESS_EN
  logic last_d_q;
  // On a tie, data wins unless it also won the previous arbitration.
  assign winner = (d_req_i && !(if_req_i && last_d_q)) ? REQ_D : REQ_IF;
`else
  assign winner = d_req_i ? REQ_D : REQ_IF;
`endif

  assign grant_any    = idle && (if_req_i || d_req_i);
  assign d_gnt_o      = grant_any && (winner == REQ_D);
  assign if_gnt_o     = grant_any && (winner == REQ_IF);
  assign stall_f_o    = !rst && if_req_i && !if_gnt_o;
  // A store with no enabled bytes has nothing to write; it retires locally.
  assign d_zero_write = d_we_i && (d_byte_en_i == 4'b0000);
  assign timer_en     = busy && !mem_ready_i;

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_any),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt_o) begin
            addr_q    <= if_addr_i;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b1111;
            mem_req_q <= 1'b1;
            state     <= BUSY_IF;
`ifdef ARB_FAIRNESS_EN
            last_d_q  <= 1'b0;
`endif
          end else if (d_gnt_o) begin
            if (d_zero_write) begin
              d_rvalid_q <= 1'b1;
              rdata_q    <= '0;
            end else begin
              addr_q    <= d_addr_i;
              wdata_q   <= d_wdata_i;
              we_q      <= d_we_i;
              be_q      <= d_byte_en_i;
              mem_req_q <= 1'b1;
              state     <= BUSY_D;
            end
`ifdef ARB_FAIRNESS_EN
            last_d_q  <= 1'b1;
`endif
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ready_i || timer_expired) begin
            // Writes and aborted transactions return zero data.
            rdata_q     <= (mem_ready_i && !we_q) ? mem_rdata_i : '0;
            err_q       <= !mem_ready_i;
            if_rvalid_q <= (state == BUSY_IF);
            d_rvalid_q  <= (state == BUSY_D);
            mem_req_q   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_byte_en_o = be_q;
  assign if_rvalid_o   = if_rvalid_q;
  assign d_rvalid_o    = d_rvalid_q;
  // Read data is only presented to the requester being completed.
  assign if_rdata_o    = if_rvalid_q ? rdata_q : '0;
  assign d_rdata_o     = d_rvalid_q ? rdata_q : '0;
  assign err_o         = err_q;

endmodule
